// File: rtl/vga_pkg.sv
// Shared VGA geometry, coordinate types and the sprite motion FSM encoding.
package vga_pkg;

  localparam int unsigned H_ACTIVE    = 640;
  localparam int unsigned V_ACTIVE    = 480;
  localparam int unsigned SPRITE_SIZE = 64;

  typedef logic [9:0] coord_t;
  typedef logic [3:0] speed_t;

  typedef enum logic [1:0] {
    IDLE,
    STEP_X,
    STEP_Y,
    DONE
  } state_t;

endpackage

// File: rtl/sprite_motion_ctrl_if.sv
// Control/status bundle between the frame timing logic and the sprite motion controller.
interface sprite_motion_ctrl_if;
  import vga_pkg::*;

  logic   frame_tick;
  logic   enable;
  speed_t speed;
  coord_t posx;
  coord_t posy;
  logic   dir_x;
  logic   dir_y;
  logic   hit_x;
  logic   hit_y;
  logic   busy;
  logic   update_done;

  modport master (
    output frame_tick, enable, speed,
    input  posx, posy, dir_x, dir_y, hit_x, hit_y, busy, update_done
  );

  modport slave (
    input  frame_tick, enable, speed,
    output posx, posy, dir_x, dir_y, hit_x, hit_y, busy, update_done
  );
endinterface

// File: rtl/axis_step.sv
// One-axis step/bounce rule, shared between x and y by the controller.
module axis_step
  import vga_pkg::*;
(
  input  coord_t p,
  input  logic   dir,
  input  speed_t speed,
  input  coord_t max,
  output coord_t p_next,
  output logic   dir_next,
  output logic   hit
);

  // 11-bit sum so a far out-of-range start position cannot wrap past the edge.
  logic [10:0] sum;
  assign sum = {1'b0, p} + {7'd0, speed};

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    p_next   = p;
    dir_next = dir;
    hit      = 1'b0;
    if (speed != '0) begin
      if (dir) begin
        if (sum >= {1'b0, max}) begin
          p_next   = max;
          dir_next = 1'b0;
          hit      = 1'b1;
        end else begin
          p_next = sum[9:0];
        end
      end else begin
        if (p <= {6'd0, speed}) begin
          p_next   = '0;
          dir_next = 1'b1;
          hit      = 1'b1;
        end else begin
          p_next = p - {6'd0, speed};
        end
      end
    end
  end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Moves one sprite during vertical blank every FRAME_DIV frames, bouncing off the screen edges.
module sprite_motion_ctrl #(
  parameter int unsigned H_ACTIVE    = vga_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE    = vga_pkg::V_ACTIVE,
  parameter int unsigned SPRITE_SIZE = vga_pkg::SPRITE_SIZE,
  parameter int unsigned INIT_X      = 0,
  parameter int unsigned INIT_Y      = 0,
  parameter int unsigned FRAME_DIV   = 1
) (
  input logic                 clk,
  input logic                 rst,
  sprite_motion_ctrl_if.slave bus
);
  import vga_pkg::*;

  localparam coord_t XMAX = coord_t'(H_ACTIVE - SPRITE_SIZE);
  localparam coord_t YMAX = coord_t'(V_ACTIVE - SPRITE_SIZE);
  localparam int unsigned DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

  state_t           state;
  state_t           state_next;
  logic [DIV_W-1:0] div_cnt;
  speed_t           speed_q;
  logic             tick_counted;
  logic             trigger;

  coord_t posx_q, posy_q;
  logic   dir_x_q, dir_y_q, hit_x_q, hit_y_q;

  coord_t op_p, op_max, step_p;
  logic   op_dir, step_dir, step_hit;

  // Ticks only count while idle and enabled; ticks during an update are dropped.
  assign tick_counted = (state == IDLE) && bus.enable && bus.frame_tick;
  assign trigger      = tick_counted && (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (trigger) state_next = STEP_X;
      STEP_X:  state_next = STEP_Y;
      STEP_Y:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy        = (state != IDLE);
    bus.update_done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      speed_q <= '0;
    end else if (tick_counted) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        speed_q <= bus.speed;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // One arithmetic unit, steered to whichever axis the FSM is stepping.
  always_comb begin
    if (state == STEP_X) begin
      op_p   = posx_q;
      op_dir = dir_x_q;
      op_max = XMAX;
    end else begin
      op_p   = posy_q;
      op_dir = dir_y_q;
      op_max = YMAX;
    end
  end

  axis_step u_axis_step (
    .p        (op_p),
    .dir      (op_dir),
    .speed    (speed_q),
    .max      (op_max),
    .p_next   (step_p),
    .dir_next (step_dir),
    .hit      (step_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      posx_q  <= coord_t'(INIT_X);
      posy_q  <= coord_t'(INIT_Y);
      dir_x_q <= 1'b1;
      dir_y_q <= 1'b1;
      hit_x_q <= 1'b0;
      hit_y_q <= 1'b0;
    end else begin
      hit_x_q <= 1'b0;
      hit_y_q <= 1'b0;
      if (state == STEP_X) begin
        posx_q  <= step_p;
        dir_x_q <= step_dir;
        hit_x_q <= step_hit;
      end
      if (state == STEP_Y) begin
        posy_q  <= step_p;
        dir_y_q <= step_dir;
        hit_y_q <= step_hit;
      end
    end
  end

  assign bus.posx  = posx_q;
  assign bus.posy  = posy_q;
  assign bus.dir_x = dir_x_q;
  assign bus.dir_y = dir_y_q;
  assign bus.hit_x = hit_x_q;
  assign bus.hit_y = hit_y_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl: three instances cover init/latency, edge bounces and the frame divider.
module tb_sprite_motion_ctrl;
  import vga_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic   rst, rst_a;
  logic   tick_r [3];
  logic   en_r   [3];
  speed_t spd_r  [3];

  logic   busy_w [3];
  logic   done_w [3];
  logic   hx_w   [3];
  logic   hy_w   [3];
  coord_t px_w   [3];
  coord_t py_w   [3];
  logic   dx_w   [3];
  logic   dy_w   [3];

  sprite_motion_ctrl_if a_if ();
  sprite_motion_ctrl_if b_if ();
  sprite_motion_ctrl_if c_if ();

  sprite_motion_ctrl #(.INIT_X(100), .INIT_Y(50), .FRAME_DIV(1)) u_a (
    .clk (clk), .rst (rst_a), .bus (a_if.slave)
  );
  sprite_motion_ctrl #(.INIT_X(570), .INIT_Y(413), .FRAME_DIV(1)) u_b (
    .clk (clk), .rst (rst), .bus (b_if.slave)
  );
  sprite_motion_ctrl #(.INIT_X(576), .INIT_Y(0), .FRAME_DIV(3)) u_c (
    .clk (clk), .rst (rst), .bus (c_if.slave)
  );

  assign a_if.frame_tick = tick_r[0];
  assign a_if.enable     = en_r[0];
  assign a_if.speed      = spd_r[0];
  assign b_if.frame_tick = tick_r[1];
  assign b_if.enable     = en_r[1];
  assign b_if.speed      = spd_r[1];
  assign c_if.frame_tick = tick_r[2];
  assign c_if.enable     = en_r[2];
  assign c_if.speed      = spd_r[2];

  assign busy_w[0] = a_if.busy;  assign done_w[0] = a_if.update_done;
  assign hx_w[0]   = a_if.hit_x; assign hy_w[0]   = a_if.hit_y;
  assign px_w[0]   = a_if.posx;  assign py_w[0]   = a_if.posy;
  assign dx_w[0]   = a_if.dir_x; assign dy_w[0]   = a_if.dir_y;
  assign busy_w[1] = b_if.busy;  assign done_w[1] = b_if.update_done;
  assign hx_w[1]   = b_if.hit_x; assign hy_w[1]   = b_if.hit_y;
  assign px_w[1]   = b_if.posx;  assign py_w[1]   = b_if.posy;
  assign dx_w[1]   = b_if.dir_x; assign dy_w[1]   = b_if.dir_y;
  assign busy_w[2] = c_if.busy;  assign done_w[2] = c_if.update_done;
  assign hx_w[2]   = c_if.hit_x; assign hy_w[2]   = c_if.hit_y;
  assign px_w[2]   = c_if.posx;  assign py_w[2]   = c_if.posy;
  assign dx_w[2]   = c_if.dir_x; assign dy_w[2]   = c_if.dir_y;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One tick on instance k, then watch 7 cycles counting busy/done/hit cycles.
  task automatic step(input int k, input speed_t spd,
                      output int nb, output int nd, output int nhx, output int nhy);
    nb = 0; nd = 0; nhx = 0; nhy = 0;
    @(negedge clk);
    spd_r[k]  = spd;
    tick_r[k] = 1'b1;
    @(negedge clk);
    tick_r[k] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (busy_w[k]) nb++;
      if (done_w[k]) nd++;
      if (hx_w[k])   nhx++;
      if (hy_w[k])   nhy++;
      @(negedge clk);
    end
  endtask

  initial begin
    int nb, nd, nhx, nhy, sum_d, sum_hx;
    for (int k = 0; k < 3; k++) begin
      tick_r[k] = 1'b0;
      en_r[k]   = 1'b1;
      spd_r[k]  = '0;
    end
    rst   = 1'b1;
    rst_a = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_posx",  px_w[0],   10'd100);
    check("rst_posy",  py_w[0],   10'd50);
    check("rst_dir_x", dx_w[0],   1'b1);
    check("rst_dir_y", dy_w[0],   1'b1);
    check("rst_busy",  busy_w[0], 1'b0);
    check("rst_done",  done_w[0], 1'b0);
    check("rst_hit",   {hx_w[0], hy_w[0]}, 2'b00);
    rst   = 1'b0;
    rst_a = 1'b0;

    // Latency: tick then busy three cycles, posx visible before posy, done in third cycle.
    @(negedge clk);
    spd_r[0]  = 4'd4;
    tick_r[0] = 1'b1;
    @(negedge clk);
    tick_r[0] = 1'b0;
    check("lat_c1_busy", busy_w[0], 1'b1);
    check("lat_c1_posx", px_w[0],   10'd100);
    @(negedge clk);
    check("lat_c2_posx", px_w[0],   10'd104);
    check("lat_c2_done", done_w[0], 1'b0);
    @(negedge clk);
    check("lat_c3_done", done_w[0], 1'b1);
    check("lat_c3_posy", py_w[0],   10'd54);
    check("lat_c3_busy", busy_w[0], 1'b1);
    @(negedge clk);
    check("lat_c4_busy", busy_w[0], 1'b0);
    check("lat_c4_done", done_w[0], 1'b0);

    // Tick arriving during STEP_Y is dropped.
    @(negedge clk);
    tick_r[0] = 1'b1;
    @(negedge clk);
    tick_r[0] = 1'b0;
    @(negedge clk);
    tick_r[0] = 1'b1;
    @(negedge clk);
    tick_r[0] = 1'b0;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      if (done_w[0]) nd++;
      @(negedge clk);
    end
    check("ign_done_cnt", nd,       1);
    check("ign_posx",     px_w[0],  10'd108);
    check("ign_posy",     py_w[0],  10'd58);

    // Reset during STEP_X aborts without writing posx.
    @(negedge clk);
    tick_r[0] = 1'b1;
    @(negedge clk);
    tick_r[0] = 1'b0;
    check("abort_busy_before", busy_w[0], 1'b1);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    check("abort_posx",  px_w[0],   10'd100);
    check("abort_posy",  py_w[0],   10'd50);
    check("abort_dirs",  {dx_w[0], dy_w[0]}, 2'b11);
    check("abort_busy",  busy_w[0], 1'b0);
    check("abort_done",  done_w[0], 1'b0);
    check("abort_hit_x", hx_w[0],   1'b0);

    // Right edge landing exactly on XMAX, bottom edge overshoot.
    step(1, 4'd6, nb, nd, nhx, nhy);
    check("bx1_posx",  px_w[1], 10'd576);
    check("bx1_dir_x", dx_w[1], 1'b0);
    check("bx1_hit_x", nhx,     1);
    check("bx1_posy",  py_w[1], 10'd416);
    check("bx1_hit_y", nhy,     1);
    check("bx1_busy",  nb,      3);
    step(1, 4'd6, nb, nd, nhx, nhy);
    check("bx2_posx",  px_w[1], 10'd570);
    check("bx2_hit_x", nhx,     0);
    check("bx2_posy",  py_w[1], 10'd410);
    for (int i = 0; i < 37; i++) step(1, 4'd11, nb, nd, nhx, nhy);
    check("by_pre_posy", py_w[1], 10'd3);
    check("by_pre_posx", px_w[1], 10'd163);
    check("by_pre_dir",  dy_w[1], 1'b0);
    step(1, 4'd5, nb, nd, nhx, nhy);
    check("by1_posy",  py_w[1], 10'd0);
    check("by1_dir_y", dy_w[1], 1'b1);
    check("by1_hit_y", nhy,     1);
    check("by1_posx",  px_w[1], 10'd158);
    step(1, 4'd5, nb, nd, nhx, nhy);
    check("by2_posy",  py_w[1], 10'd5);
    check("by2_hit_y", nhy,     0);
    check("by2_posx",  px_w[1], 10'd153);

    // Divider of 3; speed 0 at the right edge must not bounce.
    sum_d = 0; sum_hx = 0;
    for (int i = 0; i < 3; i++) begin
      step(2, 4'd0, nb, nd, nhx, nhy);
      sum_d += nd; sum_hx += nhx;
    end
    check("s0_done_cnt", sum_d,   1);
    check("s0_hit_x",    sum_hx,  0);
    check("s0_posx",     px_w[2], 10'd576);
    check("s0_dir_x",    dx_w[2], 1'b1);
    sum_d = 0; sum_hx = 0;
    for (int i = 1; i <= 7; i++) begin
      step(2, 4'd2, nb, nd, nhx, nhy);
      sum_d += nd; sum_hx += nhx;
      if (i == 2) check("div_tick2_done", nd, 0);
      if (i == 3) check("div_tick3_posx", px_w[2], 10'd576);
    end
    check("div_done_cnt", sum_d,   2);
    check("div_hit_x",    sum_hx,  1);
    check("div_posx",     px_w[2], 10'd574);
    check("div_posy",     py_w[2], 10'd4);
    en_r[2] = 1'b0;
    sum_d = 0;
    for (int i = 0; i < 5; i++) begin
      step(2, 4'd2, nb, nd, nhx, nhy);
      sum_d += nd;
    end
    check("dis_done_cnt", sum_d,   0);
    check("dis_posx",     px_w[2], 10'd574);
    en_r[2] = 1'b1;
    step(2, 4'd2, nb, nd, nhx, nhy);
    check("reen_t1_done", nd, 0);
    step(2, 4'd2, nb, nd, nhx, nhy);
    check("reen_t2_done", nd,      1);
    check("reen_posx",    px_w[2], 10'd572);
    check("reen_posy",    py_w[2], 10'd6);

    // Random-speed soak: position always stays on screen.
    for (int i = 0; i < 2000; i++) begin
      speed_t s;
      s = (i % 3 == 0) ? 4'd15 : speed_t'($urandom_range(15));
      step(0, s, nb, nd, nhx, nhy);
      check("soak_x_range", (px_w[0] <= 10'd576), 1'b1);
      check("soak_y_range", (py_w[0] <= 10'd416), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
